// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame from an
// upstream FIFO and shifts it out 8N1-style with optional even parity.
module fifo_uart_tx #(
  parameter int data_width   = 8,
  parameter int clks_per_bit = 16,
  parameter bit parity_en    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  read_enable,
  input  logic [data_width-1:0] read_data,
  input  logic                  read_empty,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int BW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] LAST_BAUD = CW'(clks_per_bit - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           baud_q, baud_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [data_width-1:0]   shift_q, shift_d;
  logic [15:0]             frames_q, frames_d;
  logic                    tx_q, tx_d;
  logic                    re_q, re_d;
  logic                    baud_last;
  logic                    bit_last;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    frames_d  = frames_q;
    baud_last = (baud_q == LAST_BAUD);
    bit_last  = (bit_q == LAST_BIT);
    unique case (state_q)
      IDLE: begin
        if (!read_empty) state_d = REQ;
      end
      REQ: state_d = LOAD;
      LOAD: begin
        shift_d = read_data;
        state_d = START;
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          if (bit_last) begin
            bit_d   = '0;
            state_d = parity_en ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_last) state_d = STOP;
      end
      STOP: begin
        if (baud_last) begin
          frames_d = frames_q + 16'd1;
          state_d  = read_empty ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // baud count restarts at every bit boundary and state change
    if (baud_last || state_d != state_q || state_q == IDLE)
      baud_d = '0;
    else
      baud_d = baud_q + CW'(1);

    re_d = (state_d == REQ);

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      PARITY:  tx_d = ^shift_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      frames_q <= '0;
      tx_q     <= 1'b1;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      frames_q <= frames_d;
      tx_q     <= tx_d;
      re_q     <= re_d;
    end
  end

  assign read_enable = re_q;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: default and parity instances,
// each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       read_enable, read_empty, tx, busy;
  logic [7:0] read_data = 8'h00;
  logic [15:0] frames_sent;
  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;

  logic       read_enable_p, read_empty_p, tx_p, busy_p;
  logic [7:0] read_data_p = 8'h00;
  logic [15:0] frames_sent_p;
  logic [7:0] mem_p [0:63];
  logic [5:0] wr_p = 6'd0;
  logic [5:0] rd_p = 6'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int re_cnt = 0;
  int re_bad = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .clk(clk),
    .reset(reset),
    .read_enable(read_enable),
    .read_data(read_data),
    .read_empty(read_empty),
    .tx(tx),
    .busy(busy),
    .frames_sent(frames_sent)
  );

  fifo_uart_tx #(.parity_en(1'b1)) dut_p (
    .clk(clk),
    .reset(reset),
    .read_enable(read_enable_p),
    .read_data(read_data_p),
    .read_empty(read_empty_p),
    .tx(tx_p),
    .busy(busy_p),
    .frames_sent(frames_sent_p)
  );

  assign read_empty   = (rd_ptr == wr_ptr);
  assign read_empty_p = (rd_p == wr_p);

  always @(posedge clk) begin
    if (read_enable) begin
      read_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
    if (read_enable_p) begin
      read_data_p <= mem_p[rd_p];
      rd_p        <= rd_p + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (read_enable) re_cnt = re_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if ((read_enable && read_empty) || (read_enable_p && read_empty_p))
      re_bad = re_bad + 1;
  end

  function automatic logic tx_of(input bit s);
    return s ? tx_p : tx;
  endfunction

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic push_p(input logic [7:0] v);
    mem_p[wr_p] = v;
    wr_p = wr_p + 6'd1;
  endtask

  task automatic wait_start(input bit s, output int n);
    n = 0;
    while (tx_of(s) !== 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Entered on the first cycle of the start bit; returns one cycle
  // after the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] v, input bit s,
                             input string nm);
    logic [10:0] seq;
    logic        last;
    int nb;
    int bad;
    nb = s ? 11 : 10;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = v[i];
    if (s) seq[9] = ^v;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      last = seq[b];
      for (int c = 0; c < 16; c++) begin
        if (tx_of(s) !== seq[b]) begin
          bad++;
          last = tx_of(s);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s bit%0d: tx=%b in %0d/16 cycles, want %b",
                 nm, b, last, bad, seq[b]);
      end
    end
  endtask

  task automatic start_ok(input bit s, input string nm);
    int n;
    wait_start(s, n);
    n_cmp++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL %s start: waited %0d cycles, want <2000", nm, n);
    end
  endtask

  task automatic gap_ok(input bit s, input string nm);
    int n;
    wait_start(s, n);
    n_cmp++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL %s gap: %0d high cycles, want 2", nm, n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL rst_tx: %b want 1", tx);
    end
    if (read_enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_re: %b want 0", read_enable);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: %b want 0", busy);
    end
    if (frames_sent !== 16'h0) begin
      n_fail++; $display("FAIL rst_frames: %h want 0000", frames_sent);
    end
    if (tx_p !== 1'b1) begin
      n_fail++; $display("FAIL rst_tx_p: %b want 1", tx_p);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_busy: %b want 0", busy);
    end
  endtask

  task automatic test_single();
    int b0, r0;
    b0 = busy_cnt;
    r0 = re_cnt;
    push(8'hA5);
    start_ok(1'b0, "a5");
    check_frame(8'hA5, 1'b0, "a5");
    repeat (5) @(negedge clk);
    n_cmp += 3;
    if (busy_cnt - b0 != 162) begin
      n_fail++; $display("FAIL a5_busy: %0d want 162", busy_cnt - b0);
    end
    if (re_cnt - r0 != 1) begin
      n_fail++; $display("FAIL a5_re: %0d want 1", re_cnt - r0);
    end
    if (frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL a5_frames: %0d want 1", frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    do_reset();
    r0 = re_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    start_ok(1'b0, "b2b0");
    check_frame(8'h00, 1'b0, "b2b0");
    gap_ok(1'b0, "b2b1");
    check_frame(8'hFF, 1'b0, "b2b1");
    gap_ok(1'b0, "b2b2");
    check_frame(8'h3C, 1'b0, "b2b2");
    repeat (4) @(negedge clk);
    n_cmp += 3;
    if (re_cnt - r0 != 3) begin
      n_fail++; $display("FAIL b2b_re: %0d want 3", re_cnt - r0);
    end
    if (frames_sent !== 16'd3) begin
      n_fail++; $display("FAIL b2b_frames: %0d want 3", frames_sent);
    end
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b tx=%b want 0 1", busy, tx);
    end
  endtask

  task automatic test_parity();
    push_p(8'h07);
    push_p(8'h03);
    start_ok(1'b1, "par07");
    check_frame(8'h07, 1'b1, "par07");
    gap_ok(1'b1, "par03");
    check_frame(8'h03, 1'b1, "par03");
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy_p !== 1'b0) begin
      n_fail++; $display("FAIL par_idle: busy=%b want 0", busy_p);
    end
  endtask

  task automatic test_idle_hold();
    int r0, low;
    r0 = re_cnt;
    low = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx !== 1'b1) low++;
      @(negedge clk);
    end
    n_cmp += 2;
    if (re_cnt - r0 != 0) begin
      n_fail++; $display("FAIL idle_re: %0d want 0", re_cnt - r0);
    end
    if (low != 0) begin
      n_fail++; $display("FAIL idle_tx: low %0d cycles want 0", low);
    end
  endtask

  task automatic test_mid_reset();
    int r0, low;
    do_reset();
    push(8'h55);
    start_ok(1'b0, "mid");
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL mid_tx: %b want 1", tx);
    end
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_busy: %b want 0", busy);
    end
    if (frames_sent !== 16'd0) begin
      n_fail++; $display("FAIL mid_frames: %0d want 0", frames_sent);
    end
    reset = 1'b0;
    r0 = re_cnt;
    low = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) low++;
      @(negedge clk);
    end
    n_cmp += 2;
    if (re_cnt - r0 != 0) begin
      n_fail++; $display("FAIL mid_re: %0d want 0", re_cnt - r0);
    end
    if (low != 0) begin
      n_fail++; $display("FAIL mid_tx_hold: low %0d want 0", low);
    end
    push(8'h5A);
    start_ok(1'b0, "mid_5a");
    check_frame(8'h5A, 1'b0, "mid_5a");
    n_cmp++;
    if (frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL mid_recover: %0d want 1", frames_sent);
    end
  endtask

  task automatic test_wrap();
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    @(negedge clk);
    push(8'hC3);
    start_ok(1'b0, "wrap");
    check_frame(8'hC3, 1'b0, "wrap");
    n_cmp++;
    if (frames_sent !== 16'h0000) begin
      n_fail++; $display("FAIL wrap: %h want 0000", frames_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_idle_hold();
    test_mid_reset();
    test_wrap();
    n_cmp++;
    if (re_bad != 0) begin
      n_fail++; $display("FAIL re_when_empty: %0d want 0", re_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter data_width, default 8: width of each word drained from the FIFO and of the serial data field.
REQ-002 Parameter clks_per_bit, default 16: clk cycles per serial bit period; the legal range is >= 2.
REQ-003 Parameter parity_en, default 0: 1 inserts an even-parity bit after the data bits.
REQ-004 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 read_enable  output  1  registered pop request to the upstream FIFO.
REQ-007 read_data  input  data_width  FIFO output word, valid the cycle after read_enable was high.
REQ-008 read_empty  input  1  FIFO empty flag; high means no word is available.
REQ-009 tx  output  1  serial line, idle-high, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frames_sent  output  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-012 The state machine SHALL have exactly these states: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-013 In IDLE with read_empty=0, the block SHALL enter REQ on the next edge; with read_empty=1 it SHALL remain in IDLE.
REQ-014 read_enable SHALL be 1 only while in REQ (exactly one cycle per word) and SHALL never be 1 in a cycle where read_empty=1.
REQ-015 REQ SHALL always go to LOAD; LOAD SHALL capture read_data into the shift register and go to START.
REQ-016 START SHALL drive tx=0 for clks_per_bit cycles, then go to DATA.
REQ-017 DATA SHALL drive data_width bits LSB first, clks_per_bit cycles each, using a bit index that counts 0..data_width-1.
REQ-018 After the last data bit, DATA SHALL go to PARITY if parity_en=1, otherwise to STOP.
REQ-019 PARITY SHALL drive the XOR of the captured word for clks_per_bit cycles (even parity), then go to STOP.
REQ-020 STOP SHALL drive tx=1 for clks_per_bit cycles.
REQ-021 On the last STOP cycle, frames_sent SHALL increment by 1, and the next state SHALL be REQ if read_empty=0, else IDLE.
REQ-022 tx SHALL be 1 in IDLE, REQ and LOAD.
REQ-023 read_empty SHALL be ignored in all states other than IDLE and the last STOP cycle.
REQ-024 The frame duration SHALL be clks_per_bit*(data_width+2+parity_en) cycles.
REQ-025 The back-to-back inter-frame gap SHALL be exactly 2 cycles of tx=1 (REQ and LOAD).
REQ-026 The baud counter SHALL be ceil(log2(clks_per_bit)) bits wide, count 0..clks_per_bit-1, and reload to 0 on every state change.
REQ-027 Captured data SHALL be unaffected by any change of read_data outside LOAD.

Reset
REQ-028 While reset=1, the block SHALL hold state=IDLE, tx=1, read_enable=0, busy=0, frames_sent=0, baud counter=0, bit index=0, and shift register=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next edge, the word is discarded, and frames_sent is not incremented.
REQ-030 Reset asserted during REQ SHALL suppress the LOAD capture; the popped word is lost, which is accepted behaviour.
REQ-031 On the first cycle after reset deasserts, the block SHALL be in IDLE and obey REQ-013.

Verification
REQ-032 Default parameters; push 0xA5 into an empty FIFO -> one read_enable pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 at 16 cycles per bit; frames_sent 0->1; busy high for 162 cycles.
REQ-033 Push 0x00, 0xFF, 0x3C back-to-back -> three read_enable pulses; each frame 160 cycles; 2-cycle tx-high gaps; frames_sent=3; return to IDLE.
REQ-034 parity_en=1; send 0x07 -> parity bit 1, frame 176 cycles; send 0x03 -> parity bit 0.
REQ-035 Assert reset at cycle 40 of a frame carrying 0x55 -> tx=1 and busy=0 next cycle; frames_sent=0; no read_enable until read_empty=0 is seen in IDLE.
REQ-036 Hold read_empty=1 for 1000 cycles -> read_enable never 1; tx constant 1.
REQ-037 Preload frames_sent to 0xFFFF by sending 65535 frames (or by force), then send one frame -> frames_sent=0x0000.
